// File: rtl/systolic_host_loader.sv
// Host-side job-stream front end for systolic_top: loads the A/B/I memories from a valid/ready stream,
// starts the array, then streams the O memory contents back out.
module systolic_host_loader #(
  parameter int INPUT_WIDTH  = 16,
  parameter int RESULT_WIDTH = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int VECTOR_DIM   = 4,
  parameter int MAX_SIZE     = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INPUT_WIDTH-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [RESULT_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [ADDR_WIDTH-1:0]   addrA,
  output logic                    enA,
  output logic [INPUT_WIDTH-1:0]  dataA,
  output logic [ADDR_WIDTH-1:0]   addrB,
  output logic                    enB,
  output logic [INPUT_WIDTH-1:0]  dataB,
  output logic [ADDR_WIDTH-1:0]   addrI,
  output logic                    enI,
  output logic [INPUT_WIDTH-1:0]  dataI,
  output logic [ADDR_WIDTH-1:0]   addrO,
  input  logic [RESULT_WIDTH-1:0] dataO,
  output logic                    ap_start,
  input  logic                    ap_done,
  output logic                    busy,
  output logic                    err
);

  localparam int NW = $clog2(MAX_SIZE + 1);
  localparam int CW = $clog2(MAX_SIZE * VECTOR_DIM + 1);
  localparam int PW = ADDR_WIDTH + 1;
  localparam int TW = PW + 2 * NW;
  localparam logic [PW-1:0] PTR_LAST  = PW'((1 << ADDR_WIDTH) - 1);
  localparam logic [TW-1:0] PTR_LIMIT = TW'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_SIZE, S_LOAD_A, S_LOAD_B, S_START, S_WAIT_DONE, S_DRAIN, S_ERROR
  } state_t;

  state_t r_state, w_next_state;

  logic                    r_in_ready, r_out_valid, r_out_last, r_ap_start, r_err;
  logic                    r_en_a, r_en_b, r_en_i;
  logic [ADDR_WIDTH-1:0]   r_addr_a, r_addr_b, r_addr_i, r_addr_o, r_o_idx;
  logic [INPUT_WIDTH-1:0]  r_data_a, r_data_b, r_data_i;
  logic [RESULT_WIDTH-1:0] r_out_data;
  logic [PW-1:0]           r_a_ptr, r_b_ptr, r_i_ptr, r_o_total;
  logic [CW-1:0]           r_cnt;
  logic [NW-1:0]           r_n;
  logic [1:0]              r_phase;

  logic          w_accept, w_size_phase, w_size_zero, w_size_bad, w_cnt_last, w_out_hs;
  logic          w_in_ready_nxt, w_wr_a, w_wr_b, w_wr_i;
  logic [CW-1:0] w_load_len;
  logic [TW-1:0] w_total_sum;

  assign w_accept     = r_in_ready & in_valid;
  assign w_size_phase = (r_state == S_IDLE) || (r_state == S_SIZE);
  assign w_size_zero  = (in_data == '0);
  // A zero size only terminates a job that already holds an instruction.
  assign w_size_bad   = in_data[INPUT_WIDTH-1] || (in_data > INPUT_WIDTH'(MAX_SIZE)) ||
                        (w_size_zero && (r_state == S_IDLE));
  assign w_load_len   = CW'(r_n) * CW'(VECTOR_DIM);
  assign w_cnt_last   = (r_cnt == w_load_len - CW'(1));
  assign w_total_sum  = TW'(r_o_total) + TW'(r_n) * TW'(r_n);
  assign w_out_hs     = (r_state == S_DRAIN) && r_out_valid && out_ready;

  // NOTE: state and every other register use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: the default at the top of each always_comb keeps every path assigned, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE, S_SIZE: if (w_accept) begin
        if (w_size_bad || (r_i_ptr == PTR_LAST)) w_next_state = S_ERROR;
        else if (w_size_zero)                    w_next_state = S_START;
        else                                     w_next_state = S_LOAD_A;
      end
      S_LOAD_A: if (w_accept) begin
        if (r_a_ptr == PTR_LAST) w_next_state = S_ERROR;
        else if (w_cnt_last)     w_next_state = S_LOAD_B;
      end
      S_LOAD_B: if (w_accept) begin
        if (r_b_ptr == PTR_LAST) w_next_state = S_ERROR;
        else if (w_cnt_last)     w_next_state = (w_total_sum >= PTR_LIMIT) ? S_ERROR : S_SIZE;
      end
      S_START:     w_next_state = S_WAIT_DONE;
      S_WAIT_DONE: if (ap_done) w_next_state = S_DRAIN;
      S_DRAIN:     if (w_out_hs && r_out_last) w_next_state = S_IDLE;
      default:     w_next_state = S_ERROR;
    endcase
  end

  // in_ready is registered from the next state so it is low while reset is asserted.
  always_comb begin
    w_in_ready_nxt = w_next_state inside {S_IDLE, S_SIZE, S_LOAD_A, S_LOAD_B};
    w_wr_i         = w_accept && w_size_phase && !w_size_bad;
    w_wr_a         = w_accept && (r_state == S_LOAD_A);
    w_wr_b         = w_accept && (r_state == S_LOAD_B);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;  r_out_valid <= 1'b0;  r_out_last <= 1'b0;
      r_ap_start  <= 1'b0;  r_err       <= 1'b0;
      r_en_a      <= 1'b0;  r_en_b      <= 1'b0;  r_en_i     <= 1'b0;
      r_addr_a    <= '0;    r_addr_b    <= '0;    r_addr_i   <= '0;
      r_addr_o    <= '0;    r_o_idx     <= '0;
      r_data_a    <= '0;    r_data_b    <= '0;    r_data_i   <= '0;
      r_out_data  <= '0;
      r_a_ptr     <= '0;    r_b_ptr     <= '0;    r_i_ptr    <= '0;
      r_o_total   <= '0;    r_cnt       <= '0;    r_n        <= '0;
      r_phase     <= '0;
    end else begin
      r_in_ready <= w_in_ready_nxt;
      r_en_a     <= w_wr_a;
      r_en_b     <= w_wr_b;
      r_en_i     <= w_wr_i;
      r_ap_start <= (r_state == S_START);
      r_err      <= r_err | (w_next_state == S_ERROR);
      if (w_wr_a) begin
        r_addr_a <= r_a_ptr[ADDR_WIDTH-1:0];
        r_data_a <= in_data;
        r_a_ptr  <= r_a_ptr + PW'(1);
      end
      if (w_wr_b) begin
        r_addr_b <= r_b_ptr[ADDR_WIDTH-1:0];
        r_data_b <= in_data;
        r_b_ptr  <= r_b_ptr + PW'(1);
      end
      if (w_wr_i) begin
        r_addr_i <= r_i_ptr[ADDR_WIDTH-1:0];
        r_data_i <= in_data;
        r_i_ptr  <= r_i_ptr + PW'(1);
        r_n      <= in_data[NW-1:0];
      end
      if (w_wr_a || w_wr_b) r_cnt <= w_cnt_last ? '0 : r_cnt + CW'(1);
      if (w_wr_b && w_cnt_last) r_o_total <= w_total_sum[PW-1:0];

      // Drain: address issued (phase 0), memory reads (phase 1), word captured and held (phase 2).
      if ((r_state == S_WAIT_DONE) && ap_done) begin
        r_o_idx  <= '0;
        r_addr_o <= '0;
        r_phase  <= '0;
      end else if (r_state == S_DRAIN) begin
        unique case (r_phase)
          2'd0: r_phase <= 2'd1;
          2'd1: begin
            r_out_data  <= dataO;
            r_out_valid <= 1'b1;
            r_out_last  <= (PW'(r_o_idx) == r_o_total - PW'(1));
            r_phase     <= 2'd2;
          end
          default: if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_phase     <= 2'd0;
            if (r_out_last) begin
              r_a_ptr   <= '0;
              r_b_ptr   <= '0;
              r_i_ptr   <= '0;
              r_o_total <= '0;
              r_o_idx   <= '0;
              r_addr_o  <= '0;
            end else begin
              r_o_idx  <= r_o_idx + ADDR_WIDTH'(1);
              r_addr_o <= r_o_idx + ADDR_WIDTH'(1);
            end
          end
        endcase
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign addrA     = r_addr_a;
  assign enA       = r_en_a;
  assign dataA     = r_data_a;
  assign addrB     = r_addr_b;
  assign enB       = r_en_b;
  assign dataB     = r_data_b;
  assign addrI     = r_addr_i;
  assign enI       = r_en_i;
  assign dataI     = r_data_i;
  assign addrO     = r_addr_o;
  assign ap_start  = r_ap_start;
  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;

endmodule
